// File: rtl/mlp_input_framer.sv
// -----------------------------------------------------------------------------
// mlp_input_framer
//
// Collects a serial stream of signed integer samples (valid/ready, one sample
// per beat), converts each sample to saturated signed Q11.20, and assembles
// exactly INPUTS samples into a parallel frame for a combinational MLP. A
// complete frame is frozen on frame_out for SETTLE_CYCLES cycles, then offered
// with frame_valid until the consumer asserts frame_ready. Frames that end
// early (err_short) or run long (err_long) are dropped with a one-cycle pulse.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   s_valid      input sample valid
//   s_ready      framer can accept a sample (FILL or DRAIN, not in reset)
//   s_data       signed integer sample, IN_WIDTH bits
//   s_last       final sample of the frame
//   frame_out    INPUTS x 32-bit signed Q(31-FRAC_BITS).FRAC_BITS frame
//   frame_valid  frame complete, settled and stable
//   frame_ready  consumer takes the frame (only looked at while frame_valid)
//   err_short    one-cycle pulse: s_last before INPUTS samples
//   err_long     one-cycle pulse: overlong frame drained up to its s_last
//   frame_count  frames delivered, wraps modulo 2^16
// -----------------------------------------------------------------------------
module mlp_input_framer #(
  parameter int INPUTS        = 9,
  parameter int IN_WIDTH      = 16,
  parameter int FRAC_BITS     = 20,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [IN_WIDTH-1:0] s_data,
  input  logic                       s_last,
  output logic signed [31:0]         frame_out [0:INPUTS-1],
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       err_short,
  output logic                       err_long,
  output logic [15:0]                frame_count
);

  localparam int IDX_W  = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  // Wide enough for the shifted sample and for at least one bit above the
  // 32-bit result, so the overflow test below always has something to inspect.
  localparam int WIDE_W = (IN_WIDTH + FRAC_BITS > 32) ? IN_WIDTH + FRAC_BITS : 33;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUTS - 1);
  // The SETTLE state is entered with SETTLE_CYCLES-1 and left when it reads 0,
  // so it occupies exactly SETTLE_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    SETTLE,
    VALID
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_short_q, err_short_d;
  logic               err_long_q, err_long_d;
  logic [15:0]        count_q, count_d;
  logic signed [31:0] frame_q [0:INPUTS-1];

  logic               beat;
  logic               wr_en;
  logic signed [WIDE_W-1:0] wide;
  logic signed [31:0] sample_fx;

  // Reset forces s_ready low in the very cycle it is asserted.
  assign s_ready = !rst && ((state_q == FILL) || (state_q == DRAIN));
  assign beat    = s_valid && s_ready;

  // Sign-extend, scale, then clamp to the 32-bit signed range. The value fits
  // when every bit from 31 upward equals the sign bit.
  always_comb begin
    wide = WIDE_W'(s_data) <<< FRAC_BITS;
    if ((wide[WIDE_W-1:31] == '0) || (wide[WIDE_W-1:31] == '1)) begin
      sample_fx = wide[31:0];
    end else if (wide[WIDE_W-1]) begin
      sample_fx = 32'sh8000_0000;
    end else begin
      sample_fx = 32'sh7FFF_FFFF;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    count_d     = count_q;
    wr_en       = 1'b0;

    case (state_q)
      FILL: begin
        if (beat) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (!s_last) begin
              state_d = DRAIN;
            end else if (SETTLE_CYCLES == 0) begin
              state_d = VALID;
            end else begin
              state_d = SETTLE;
              cnt_d   = CNT_LOAD;
            end
          end else if (s_last) begin
            // Early s_last: drop the partial frame and start over.
            err_short_d = 1'b1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      DRAIN: begin
        if (beat && s_last) begin
          err_long_d = 1'b1;
          state_d    = FILL;
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = VALID;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      VALID: begin
        if (frame_ready) begin
          count_d = count_q + 16'd1;
          state_d = FILL;
        end
      end

      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the values from before this edge regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      cnt_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      count_q     <= '0;
      // NOTE: the frame store is cleared on reset because the consumer sees
      // it directly and a reset must leave frame_out at all zeros.
      for (int i = 0; i < INPUTS; i++) begin
        frame_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      count_q     <= count_d;
      if (wr_en) begin
        frame_q[idx_q] <= sample_fx;
      end
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = (state_q == VALID);
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_mlp_input_framer.sv
// -----------------------------------------------------------------------------
// tb_mlp_input_framer
//
// Directed bench for mlp_input_framer. A frame-level model (count beats per
// frame, remaining settle cycles, presenting flag) predicts every output and is
// compared on each falling edge; directed scenarios add hand-computed literal
// expectations for frame contents, latency, counts and error pulses.
// -----------------------------------------------------------------------------
module tb_mlp_input_framer;

  localparam int INPUTS        = 9;
  localparam int IN_WIDTH      = 16;
  localparam int FRAC_BITS     = 20;
  localparam int SETTLE_CYCLES = 2;
  localparam int ONE           = 1048576;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       s_valid = 1'b0;
  logic                       s_ready;
  logic signed [IN_WIDTH-1:0] s_data = '0;
  logic                       s_last = 1'b0;
  logic signed [31:0]         frame_out [0:INPUTS-1];
  logic                       frame_valid;
  logic                       frame_ready = 1'b1;
  logic                       err_short;
  logic                       err_long;
  logic [15:0]                frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int err_s_seen = 0;
  int err_l_seen = 0;
  int fv_seen    = 0;

  logic signed [IN_WIDTH-1:0] vec [16];

  mlp_input_framer #(
    .INPUTS(INPUTS),
    .IN_WIDTH(IN_WIDTH),
    .FRAC_BITS(FRAC_BITS),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .frame_out(frame_out),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .err_short(err_short),
    .err_long(err_long),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [31:0] to_q20(input int d);
    longint v;
    v = longint'(d) * (longint'(1) << FRAC_BITS);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  logic [31:0] m_frame [INPUTS];
  int          m_beats   = 0;
  int          m_wait    = 0;
  bit          m_present = 1'b0;
  bit          m_err_s   = 1'b0;
  bit          m_err_l   = 1'b0;
  int          m_count   = 0;
  bit          m_live    = 1'b0;

  always @(posedge clk) begin : model
    int nb;
    m_err_s <= 1'b0;
    m_err_l <= 1'b0;
    if (rst) begin
      m_live    <= 1'b1;
      m_beats   <= 0;
      m_wait    <= 0;
      m_present <= 1'b0;
      m_count   <= 0;
      for (int i = 0; i < INPUTS; i++) m_frame[i] <= '0;
    end else if (m_present) begin
      if (frame_ready) begin
        m_present <= 1'b0;
        m_count   <= (m_count + 1) % 65536;
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_present <= 1'b1;
    end else if (s_valid) begin
      nb = m_beats + 1;
      if (nb <= INPUTS) m_frame[nb-1] <= to_q20(int'(s_data));
      if (!s_last) begin
        m_beats <= nb;
      end else begin
        m_beats <= 0;
        if (nb < INPUTS) m_err_s <= 1'b1;
        else if (nb > INPUTS) m_err_l <= 1'b1;
        else if (SETTLE_CYCLES == 0) m_present <= 1'b1;
        else m_wait <= SETTLE_CYCLES;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("s_ready", 32'(s_ready), 32'(!rst && !m_present && (m_wait == 0)));
      check("frame_valid", 32'(frame_valid), 32'(m_present));
      check("err_short", 32'(err_short), 32'(m_err_s));
      check("err_long", 32'(err_long), 32'(m_err_l));
      check("frame_count", 32'(frame_count), 32'(m_count));
      for (int i = 0; i < INPUTS; i++)
        check($sformatf("frame_out[%0d]", i), frame_out[i], m_frame[i]);
    end
    if (err_short) err_s_seen++;
    if (err_long) err_l_seen++;
    if (frame_valid) fv_seen++;
  end

  // ---------------------------------------------------------------- stimulus
  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic beat(input logic signed [IN_WIDTH-1:0] d, input logic last);
    bit got;
    got = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = s_ready;
      if (got) last_cyc = cyc;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!got) begin
      n_fail++;
      $display("FAIL beat_timeout: got s_ready=0 for 200 cycles, expected 1");
    end
  endtask

  task automatic idle_cycle();
    s_valid = 1'b0;
    s_data  = 16'($urandom);
    s_last  = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
      end
      beat(vec[i], (i == n - 1));
    end
  endtask

  // Returns on the falling edge where frame_valid is first seen high.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (frame_valid) begin
        lat = cyc - last_cyc;
        break;
      end
    end
    if (lat < 0) begin
      n_fail++;
      $display("FAIL wait_valid: got no frame_valid within 100 cycles, expected one");
    end
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sat_exp [INPUTS] = '{32'h7FF0_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                                    32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                    32'h0000_0000, 32'h0010_0000, 32'hFFF0_0000};

  initial begin : stim
    int lat;
    int e0;
    int f0;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(frame_count), 32'd0);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_frame0", frame_out[0], 32'd0);
    realign();

    // Basic frame 1..9
    for (int i = 0; i < INPUTS; i++) vec[i] = 16'(i + 1);
    send(INPUTS, 1'b0);
    wait_valid(lat);
    check("basic_latency", 32'(lat), 32'd3);
    for (int i = 0; i < INPUTS; i++) begin
      check($sformatf("basic_el[%0d]", i), frame_out[i], 32'((i + 1) * ONE));
      check($sformatf("model_basic[%0d]", i), m_frame[i], 32'((i + 1) * ONE));
    end
    @(negedge clk);
    check("basic_valid_drop", 32'(frame_valid), 32'd0);
    check("basic_count", 32'(frame_count), 32'd1);
    realign();

    // Saturation
    vec[0] = 16'sd2047;  vec[1] = 16'sd2048;  vec[2] = 16'sd32767;
    vec[3] = -16'sd2048; vec[4] = -16'sd2049; vec[5] = -16'sd32768;
    vec[6] = 16'sd0;     vec[7] = 16'sd1;     vec[8] = -16'sd1;
    send(INPUTS, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < INPUTS; i++) begin
      check($sformatf("sat_el[%0d]", i), frame_out[i], sat_exp[i]);
      check($sformatf("model_sat[%0d]", i), m_frame[i], sat_exp[i]);
    end
    realign();

    // Backpressure: 20 cycles with frame_ready low and junk beats offered
    frame_ready = 1'b0;
    for (int i = 0; i < INPUTS; i++) vec[i] = 16'(50 * i - 200);
    send(INPUTS, 1'b0);
    wait_valid(lat);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      s_valid = 1'b1;
      s_data  = 16'($urandom);
      s_last  = 1'($urandom);
      @(negedge clk);
      check("bp_valid", 32'(frame_valid), 32'd1);
      check("bp_ready", 32'(s_ready), 32'd0);
      for (int i = 0; i < INPUTS; i++)
        check($sformatf("bp_el[%0d]", i), frame_out[i], 32'((50 * i - 200) * ONE));
    end
    realign();
    s_valid = 1'b0;
    s_last  = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    check("bp_still_valid", 32'(frame_valid), 32'd1);
    @(negedge clk);
    check("bp_released", 32'(frame_valid), 32'd0);
    check("bp_count", 32'(frame_count), 32'd3);
    realign();

    // Short frame, then a good frame
    e0 = err_s_seen;
    f0 = fv_seen;
    for (int i = 0; i < 5; i++) vec[i] = 16'(i + 1);
    send(5, 1'b0);
    repeat (4) @(negedge clk);
    check("short_pulses", 32'(err_s_seen - e0), 32'd1);
    check("short_no_valid", 32'(fv_seen - f0), 32'd0);
    realign();
    for (int i = 0; i < INPUTS; i++) vec[i] = 16'(11 + i);
    send(INPUTS, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < INPUTS; i++)
      check($sformatf("after_short_el[%0d]", i), frame_out[i], 32'((11 + i) * ONE));
    @(negedge clk);
    check("after_short_count", 32'(frame_count), 32'd4);
    realign();

    // Long frame (12 beats), then a good frame starting at index 0
    e0 = err_l_seen;
    f0 = fv_seen;
    for (int i = 0; i < 12; i++) vec[i] = 16'(i + 1);
    send(12, 1'b0);
    repeat (4) @(negedge clk);
    check("long_pulses", 32'(err_l_seen - e0), 32'd1);
    check("long_no_valid", 32'(fv_seen - f0), 32'd0);
    realign();
    for (int i = 0; i < INPUTS; i++) vec[i] = 16'(21 + i);
    send(INPUTS, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < INPUTS; i++)
      check($sformatf("after_long_el[%0d]", i), frame_out[i], 32'((21 + i) * ONE));
    @(negedge clk);
    check("after_long_count", 32'(frame_count), 32'd5);
    realign();

    // Random s_valid stalls mid-frame
    for (int i = 0; i < INPUTS; i++) vec[i] = 16'(100 * i - 400);
    send(INPUTS, 1'b1);
    wait_valid(lat);
    for (int i = 0; i < INPUTS; i++)
      check($sformatf("stall_el[%0d]", i), frame_out[i], 32'((100 * i - 400) * ONE));
    @(negedge clk);
    check("stall_count", 32'(frame_count), 32'd6);
    realign();

    // Reset while frame_valid is high
    frame_ready = 1'b0;
    for (int i = 0; i < INPUTS; i++) vec[i] = 16'(i + 3);
    send(INPUTS, 1'b0);
    wait_valid(lat);
    realign();
    rst = 1'b1;
    realign();
    rst = 1'b0;
    @(negedge clk);
    check("rstv_valid", 32'(frame_valid), 32'd0);
    check("rstv_count", 32'(frame_count), 32'd0);
    check("rstv_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < INPUTS; i++)
      check($sformatf("rstv_el[%0d]", i), frame_out[i], 32'd0);
    realign();
    frame_ready = 1'b1;
    for (int i = 0; i < INPUTS; i++) vec[i] = 16'(-i - 1);
    send(INPUTS, 1'b0);
    wait_valid(lat);
    check("rstv_latency", 32'(lat), 32'd3);
    for (int i = 0; i < INPUTS; i++)
      check($sformatf("rstv_next_el[%0d]", i), frame_out[i], 32'((-i - 1) * ONE));
    @(negedge clk);
    check("rstv_next_count", 32'(frame_count), 32'd1);
    realign();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test by 500000, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
